// File: rtl/burst_mem_pkg.sv
// Shared types and helpers for the burst_mem block: FSM state encoding,
// command opcodes and the even-parity helper used by the optional
// BURST_MEM_PARITY_EN storage path.
package burst_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

   // Wide enough for any sensible data word; callers zero-extend with a cast,
   // which leaves the parity unchanged.
   localparam int PAR_W = 256;

   function automatic logic even_parity(input logic [PAR_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Storage for burst_mem: synchronous single-port write, registered read with
// a valid strobe. With BURST_MEM_PARITY_EN defined, each word carries an
// even-parity bit that is checked on the read path.
module burst_mem_array
   import burst_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data
`ifdef BURST_MEM_PARITY_EN
  ,input  logic                  force_perr
  ,output logic                  rd_perr
`endif
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

   // Read pipeline: one-cycle latency, valid strobe follows the read enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            rd_data <= mem[addr];
         end
      end
   end

`ifdef BURST_MEM_PARITY_EN
   logic par_mem [DEPTH];
   logic par_p1;

   // Parity write; force_perr flips the stored bit to inject an error.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         par_mem[addr] <= even_parity(PAR_W'(wr_data)) ^ force_perr;
      end
   end

   // Stored parity travels alongside the registered read word.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         par_p1 <= par_mem[addr];
      end
   end

   assign rd_perr = rd_valid & (par_p1 ^ even_parity(PAR_W'(rd_data)));
`endif

endmodule

// File: rtl/burst_mem.sv
// burst_mem top: command handshake, burst FSM (IDLE/WRITE/READ/DONE) with
// address auto-increment modulo DEPTH, write-beat stalling and a registered
// read path. Optional parity storage is enabled by defining
// BURST_MEM_PARITY_EN, which adds the force_perr input and rd_perr output.
module burst_mem
   import burst_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr_rd,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  done
`ifdef BURST_MEM_PARITY_EN
  ,input  logic                  force_perr
  ,output logic                  rd_perr
`endif
);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  wr_en;
   logic                  rd_en;

   // State, address and remaining-beat registers; reset aborts any burst.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and handshake decode; the address wraps naturally at DEPTH.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      cmd_ready = 1'b0;
      wr_ready  = 1'b0;
      wr_en     = 1'b0;
      rd_en     = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               cnt_d   = cmd_len;
               state_d = (cmd_wr_rd == WR) ? WRITE : READ;
            end
         end
         WRITE: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               wr_en  = 1'b1;
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  state_d = DONE;
               end
            end
         end
         READ: begin
            // No backpressure: one beat issued every cycle.
            rd_en  = 1'b1;
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   burst_mem_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .addr       (addr_q),
      .wr_data    (wr_data),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data)
`ifdef BURST_MEM_PARITY_EN
     ,.force_perr (force_perr)
     ,.rd_perr    (rd_perr)
`endif
   );

endmodule

// File: doc/burst_mem.md
Name: burst_mem

Overview:
- Parametrised single-port synchronous memory; next generation of the team's `mem` block.
- Adds a command handshake, multi-beat bursts with address auto-increment and wrap, write-beat stalling, and a registered read-data pipeline with a valid strobe.
- Sits between a bus-side master (DMA, testbench driver) and on-chip storage.

Parameters:
- ADDR_WIDTH, 8, word-address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, data word width.
- LEN_WIDTH, 4, burst length field width; max burst = 2**LEN_WIDTH beats.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command.
- cmd_wr_rd  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDR_WIDTH  start word address.
- cmd_len  input  LEN_WIDTH  beats minus one.
- wr_valid  input  1  write beat present.
- wr_data  input  DATA_WIDTH  write beat data.
- wr_ready  output  1  write beat accepted this cycle.
- rd_valid  output  1  rd_data valid this cycle.
- rd_data  output  DATA_WIDTH  read beat data.
- done  output  1  one-cycle pulse after the last beat of any burst.

Behaviour:
- Reset (rst = 0, async):
  - FSM goes to IDLE.
  - cmd_ready=1, wr_ready=0, rd_valid=0, rd_data=0, done=0.
  - Internal addr and beat counters are cleared.
  - Storage contents are not reset.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, the command is captured: addr_q=cmd_addr, cnt_q=cmd_len.
  - Next state is WRITE if cmd_wr_rd=1, else READ.
  - cmd_ready=0 in every other state; commands are held off, not dropped.
- WRITE:
  - wr_ready=1 combinationally in WRITE.
  - A beat transfers when wr_valid && wr_ready: mem[addr_q] <= wr_data, then addr_q++ and cnt_q--.
  - wr_valid=0 stalls the burst with no state change and no cycle limit.
  - The beat with cnt_q==0 goes to DONE.
- READ:
  - Each cycle, mem[addr_q] is read and registered; rd_valid=1 on the next cycle (latency 1 from the READ entry edge).
  - There is no backpressure: exactly cmd_len+1 consecutive rd_valid cycles.
  - The beat with cnt_q==0 goes to DONE. The last rd_valid aligns with the DONE cycle.
- DONE: done=1 for one cycle, then IDLE. The earliest next command is accepted one cycle after DONE.
- Address arithmetic: addr_q is modulo DEPTH; a burst crossing DEPTH-1 wraps to 0.
- cmd_len: 0 means a single beat; all-ones means 2**LEN_WIDTH beats.
- Read-after-write to the same address in separate bursts returns the new data; there is no same-cycle hazard because the port is single.
- Reset mid-burst:
  - The burst is aborted and the FSM returns to IDLE.
  - Beats already written remain in storage.
  - No done pulse is generated.
  - rd_valid drops immediately (async).
- cmd_valid during reset release is ignored until the first posedge with rst=1.

Optional Feature:
- Macro BURST_MEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on write.
  - The read path recomputes parity.
  - New output rd_perr (1 bit) is asserted with rd_valid when the stored and recomputed parity mismatch; reset value 0.
  - Port `force_perr` (input, 1) inverts the stored parity on write, for test.
- Undefined: no parity storage, no rd_perr or force_perr ports; behaviour is otherwise identical.

Decomposition:
- Package burst_mem_pkg holds:
  - the state typedef enum {IDLE, WRITE, READ, DONE};
  - the WR=1'b1 and RD=1'b0 opcode constants;
  - a parity helper function.
- Sub-module burst_mem_array holds the storage array, synchronous write, registered read and optional parity bits.
- The top level holds the FSM and counters.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release → cmd_ready=1, rd_valid=0, done=0, rd_data=0.
- Single write then read:
  - Write addr 0x10, len 0, data 0xDEADBEEF → done after 1 beat.
  - Read addr 0x10, len 0 → one rd_valid with rd_data=0xDEADBEEF.
- Burst with stalls:
  - Write addr 0x20, len 3, data 0x1..0x4 with wr_valid low for 2 cycles between beats 2 and 3 → exactly 4 wr_ready&&wr_valid transfers.
  - Read back addr 0x20 len 3 → 0x1, 0x2, 0x3, 0x4 on 4 consecutive rd_valid cycles.
- Wrap-around:
  - Write addr 0xFE, len 3, data 0xA..0xD.
  - Read addr 0x00 len 1 → 0xC, 0xD.
  - Read addr 0xFE len 1 → 0xA, 0xB.
- Back-pressure on commands: assert cmd_valid continuously during an active 16-beat read → cmd_ready=0 until after done; the second command is accepted on the cycle after DONE.
- Reset mid-burst:
  - Assert rst=0 after beat 2 of a len 7 write to 0x40.
  - Afterwards there is no done pulse, FSM is IDLE, and reading 0x40 len 1 returns beats 1–2.
  - With BURST_MEM_PARITY_EN: write with force_perr=1, read back → rd_perr=1.
